// File: rtl/mtl1_pkg.sv
// Shared types and constants for the SPI flash arbiter.
// Holds the arbiter state enum, SPI idle levels and defaults.
package mtl1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_WR,
    ST_GUARD
  } arb_state_e;

  typedef enum logic {
    OWN_CTRL,
    OWN_WR
  } owner_e;

  localparam logic SPI_CS_IDLE   = 1'b1;
  localparam logic SPI_CLK_IDLE  = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b0;

  localparam int DEF_GUARD_CYCLES   = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES    = 2;

  // Shared watchdog/guard counter: never narrower than 10 bits.
  function automatic int cnt_width(int timeout, int guard);
    int w;
    w = 10;
    if ($clog2(timeout + 1) > w) w = $clog2(timeout + 1);
    if ($clog2(guard + 1) > w) w = $clog2(guard + 1);
    return w;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// N-flop single-bit synchronizer with async active-low clear.
// Used to bring the FT2232 writer request into the clk domain.
module cdc_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash arbiter: 6809 read controller vs FT2232 writer.
// Fair tie-break, no preemption, CS guard gap, controller watchdog.
module spi_flash_arbiter
  import mtl1_pkg::*;
#(
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ctrl_req,
  input  logic i_ctrl_spi_clk,
  input  logic i_ctrl_spi_mosi,
  input  logic i_ctrl_spi_cs,
  input  logic i_wr_req_n,
  input  logic i_wr_spi_clk,
  input  logic i_wr_spi_mosi,
  input  logic i_wr_spi_cs,
  output logic o_SPI_CLK,
  output logic o_SPI_MOSI,
  output logic o_SPI_CS,
  output logic o_ctrl_gnt,
  output logic o_wr_gnt,
  output logic o_ctrl_wait,
  output logic o_timeout
);

  localparam int GC = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int CW = cnt_width(TIMEOUT_CYCLES, GC);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q;
  owner_e        last_q;
  logic [CW-1:0] cnt_q;
  logic          ctrl_gnt_q;
  logic          wr_gnt_q;
  logic          timeout_q;
  logic          wr_req_s;

  cdc_sync #(
    .N(SYNC_STAGES)
  ) u_wr_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (~i_wr_req_n),
    .q_o  (wr_req_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_q     <= OWN_WR;
      cnt_q      <= '0;
      ctrl_gnt_q <= 1'b0;
      wr_gnt_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // On a tie the requester not served last wins.
          if (i_ctrl_req && (!wr_req_s || last_q == OWN_WR)) begin
            state_q    <= ST_CTRL;
            ctrl_gnt_q <= 1'b1;
            last_q     <= OWN_CTRL;
            cnt_q      <= '0;
          end else if (wr_req_s) begin
            state_q  <= ST_WR;
            wr_gnt_q <= 1'b1;
            last_q   <= OWN_WR;
          end
        end
        ST_CTRL: begin
          if (cnt_q == TO_LAST) begin
            state_q    <= ST_GUARD;
            ctrl_gnt_q <= 1'b0;
            timeout_q  <= 1'b1;
            cnt_q      <= GUARD_LOAD;
          end else if (!i_ctrl_req && i_ctrl_spi_cs) begin
            state_q    <= ST_GUARD;
            ctrl_gnt_q <= 1'b0;
            cnt_q      <= GUARD_LOAD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR: begin
          if (!wr_req_s && i_wr_spi_cs) begin
            state_q  <= ST_GUARD;
            wr_gnt_q <= 1'b0;
            cnt_q    <= GUARD_LOAD;
          end
        end
        ST_GUARD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_SPI_CS   = SPI_CS_IDLE;
    o_SPI_CLK  = SPI_CLK_IDLE;
    o_SPI_MOSI = SPI_MOSI_IDLE;
    if (ctrl_gnt_q) begin
      o_SPI_CS   = i_ctrl_spi_cs;
      o_SPI_CLK  = i_ctrl_spi_clk;
      o_SPI_MOSI = i_ctrl_spi_mosi;
    end else if (wr_gnt_q) begin
      o_SPI_CS   = i_wr_spi_cs;
      o_SPI_CLK  = i_wr_spi_clk;
      o_SPI_MOSI = i_wr_spi_mosi;
    end
  end

  assign o_ctrl_gnt  = ctrl_gnt_q;
  assign o_wr_gnt    = wr_gnt_q;
  assign o_timeout   = timeout_q;
  assign o_ctrl_wait = i_ctrl_req & ~ctrl_gnt_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter against a transaction-level
// model of owner, guard gap, watchdog age and fair tie-break.
module tb_spi_flash_arbiter;

  localparam int GUARD = 3;
  localparam int TMO   = 1024;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic i_ctrl_req = 1'b0;
  logic i_ctrl_spi_clk = 1'b0;
  logic i_ctrl_spi_mosi = 1'b0;
  logic i_ctrl_spi_cs = 1'b1;
  logic i_wr_req_n = 1'b1;
  logic i_wr_spi_clk = 1'b0;
  logic i_wr_spi_mosi = 1'b0;
  logic i_wr_spi_cs = 1'b1;
  logic o_SPI_CLK, o_SPI_MOSI, o_SPI_CS;
  logic o_ctrl_gnt, o_wr_gnt, o_ctrl_wait, o_timeout;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .GUARD_CYCLES  (GUARD),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_ctrl_req     (i_ctrl_req),
    .i_ctrl_spi_clk (i_ctrl_spi_clk),
    .i_ctrl_spi_mosi(i_ctrl_spi_mosi),
    .i_ctrl_spi_cs  (i_ctrl_spi_cs),
    .i_wr_req_n     (i_wr_req_n),
    .i_wr_spi_clk   (i_wr_spi_clk),
    .i_wr_spi_mosi  (i_wr_spi_mosi),
    .i_wr_spi_cs    (i_wr_spi_cs),
    .o_SPI_CLK      (o_SPI_CLK),
    .o_SPI_MOSI     (o_SPI_MOSI),
    .o_SPI_CS       (o_SPI_CS),
    .o_ctrl_gnt     (o_ctrl_gnt),
    .o_wr_gnt       (o_wr_gnt),
    .o_ctrl_wait    (o_ctrl_wait),
    .o_timeout      (o_timeout)
  );

  typedef struct packed {
    logic cg;
    logic wg;
    logic tmo;
    logic wt;
    logic cs;
    logic sck;
    logic mosi;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: who owns the flash (0 none, 1 ctrl, 2 writer), remaining
  // guard cycles, cycles the controller has held, last one served.
  int own;
  int guard_left;
  int held;
  int last;
  bit wq[$];

  function automatic obs_t observe();
    return {o_ctrl_gnt, o_wr_gnt, o_timeout, o_ctrl_wait,
            o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
  endfunction

  task automatic model_reset();
    own = 0;
    guard_left = 0;
    held = 0;
    last = 2;
    wq = {};
    repeat (SYNC) wq.push_back(1'b0);
  endtask

  task automatic check_now(input string name, input logic [5:0] got,
                           input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Drive inputs for the coming edge and predict the post-edge outputs.
  task automatic apply(input bit creq, input bit ccs,
                       input bit wrn, input bit wcs);
    bit ws;
    bit tmo;
    obs_t e;
    i_ctrl_req      = creq;
    i_ctrl_spi_cs   = ccs;
    i_ctrl_spi_clk  = 1'($urandom);
    i_ctrl_spi_mosi = 1'($urandom);
    i_wr_req_n      = wrn;
    i_wr_spi_cs     = wcs;
    i_wr_spi_clk    = 1'($urandom);
    i_wr_spi_mosi   = 1'($urandom);
    ws = wq.pop_front();
    wq.push_back(!wrn);
    tmo = 1'b0;
    if (own == 1) begin
      if (held == TMO - 1) begin
        own = 0;
        guard_left = GUARD;
        tmo = 1'b1;
      end else if (!creq && ccs) begin
        own = 0;
        guard_left = GUARD;
      end else begin
        held++;
      end
    end else if (own == 2) begin
      if (!ws && wcs) begin
        own = 0;
        guard_left = GUARD;
      end
    end else if (guard_left > 0) begin
      guard_left--;
    end else if (creq || ws) begin
      if (creq && ws) own = (last == 2) ? 1 : 2;
      else own = creq ? 1 : 2;
      last = own;
      held = 0;
    end
    e.cg   = (own == 1);
    e.wg   = (own == 2);
    e.tmo  = tmo;
    e.wt   = creq && (own != 1);
    e.cs   = (own == 1) ? ccs : (own == 2) ? wcs : 1'b1;
    e.sck  = (own == 1) ? i_ctrl_spi_clk : (own == 2) ? i_wr_spi_clk : 1'b0;
    e.mosi = (own == 1) ? i_ctrl_spi_mosi :
             (own == 2) ? i_wr_spi_mosi : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit creq, input bit ccs,
                     input bit wrn, input bit wcs);
    @(negedge clk);
    apply(creq, ccs, wrn, wcs);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_now(name, {o_ctrl_gnt, o_wr_gnt, o_timeout,
                     o_SPI_CS, o_SPI_CLK, o_SPI_MOSI}, 6'b000100);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observe();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard at %0t got %b want %b (cg wg tmo wt cs sck mosi)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : stim
    bit creq, ccs, wrn, wcs;
    int n;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check_now("reset_initial", {o_ctrl_gnt, o_wr_gnt, o_timeout,
                                o_SPI_CS, o_SPI_CLK, o_SPI_MOSI}, 6'b000100);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b1, 1'b1, 1'b1);

    // Controller alone: hold 8 cycles, then release with CS high.
    repeat (8) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Writer alone, SPI pins toggling while granted.
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Two genuine ties; the second goes to the other requester.
    do_reset("reset_before_tie");
    for (int t = 0; t < 2; t++) begin
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Writer requests while controller owns: no preemption.
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Controller never lets go: watchdog fires, then re-grant.
    repeat (1100) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset while writer granted and driving CS low.
    n = 0;
    while (own != 2 && n < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (own != 2) begin
      errors++;
      $display("FAIL wr_grant_timeout own=%0d want 2", own);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset("reset_mid_wr");
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Random traffic with sticky requests.
    creq = 0; ccs = 1; wrn = 1; wcs = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) creq = !creq;
      if ($urandom_range(9) == 0) wrn = !wrn;
      ccs = ($urandom_range(3) != 0);
      wcs = ($urandom_range(3) != 0);
      cyc(creq, ccs, wrn, wcs);
      if (i == 2000) do_reset("reset_random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
